mux2_rr_arbiter: RTL
====================

# mux2_rr_arbiter

Two-input packet arbiter that sits directly upstream of the 2:1 multiplexer stage. It drives that stage's select and delivers the chosen word through a registered output. It arbitrates two valid/ready streams with round-robin fairness and holds the grant for the whole packet, from the first beat through the beat flagged `last`. Steady-state throughput is one word per clock, and latency is one cycle.

## Interface
- `W`, default 8: data width of each input and of the output.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in0_valid`  input  1  channel 0 word present.
- `in0_data`  input  W  channel 0 word.
- `in0_last`  input  1  channel 0 final beat of packet.
- `in0_ready`  output  1  channel 0 word accepted this cycle.
- `in1_valid`, `in1_data`, `in1_last`, `in1_ready`: same as channel 0, for channel 1.
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  W  registered selected word.
- `out_last`  output  1  registered last flag of that word.
- `out_ready`  input  1  downstream accepts the word.
- `sel`  output  1  registered source of the word in the output register (0 = in0, 1 = in1). This is the select for the downstream 2:1 mux.

## Operation
- Transfer rule: a transfer occurs on any interface when valid and ready are both 1 at a rising edge.
- Output register load enable: `load = !out_valid | out_ready`.
- State machine, 2-bit state register:
  - IDLE: no packet open.
  - LOCK0: packet on channel 0 open.
  - LOCK1: packet on channel 1 open.
- Grant, combinational:
  - IDLE, both valid: grant = `prio`.
  - IDLE, one valid: grant = that channel.
  - IDLE, none valid: no grant.
  - LOCKi: grant = i only. The other channel is never granted, even if it is valid.
- Ready: `ini_ready = load & granted(i)`. At most one ready is high per cycle. Ready must not depend on `out_valid` of any other block.
- On an accept from channel i:
  - `out_data <= ini_data`, `out_last <= ini_last`, `sel <= i`, `out_valid <= 1`.
- State transitions on an accept from channel i:
  - `last=0`: next state is LOCKi.
  - `last=1`: next state is IDLE and `prio <= ~i`.
  - A single-beat packet accepted in IDLE stays in IDLE and still flips `prio`.
- No accept while load is high: `out_valid <= 0` once `out_ready` takes the word.
- No accept while load is low: the output register holds all fields, and `sel` stays stable.
- `prio` changes only at packet end, never mid-packet.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - `out_valid`=0, `out_data`=0, `out_last`=0, `sel`=0.
  - state = IDLE, `prio`=0, so channel 0 wins the first contention.
  - Both readys read 0 while in reset. This follows from the state values and `out_valid`=0 together with `rst_n` gating the readys.
- Latency: input accept at edge N gives `out_valid`=1 with that word after edge N.
- Throughput: with `out_ready` held at 1, a new word is accepted every cycle. Back-to-back packets from alternating channels lose no cycles.
- Backpressure: `out_ready`=0 while `out_valid`=1 forces both readys to 0, and the output stays frozen.
- Simultaneous output drain and refill in the same cycle: the new word replaces the old one, and `out_valid` stays 1.
- Reset mid-packet: the open packet is abandoned. After reset the block is in IDLE with `prio`=0, and it must not emit any residual beats.
- Gaps within a locked packet: `ini_valid`=0 while in LOCKi produces no accept and holds the lock. The other channel stays blocked.

## Test plan
- Reset, then a single-beat word from in0 only (data=0x11, last=1): in0_ready=1 in that cycle. Next cycle out_valid=1, out_data=0x11, sel=0, out_last=1. State IDLE, prio=1.
- Both channels valid, all single-beat, out_ready=1, in0 words 0xA0,0xA1 and in1 words 0xB0,0xB1: output order 0xA0,0xB0,0xA1,0xB1. sel toggles 0,1,0,1 with no idle cycles.
- Packet lock: in0 sends 3 beats 0x01,0x02,0x03 (last on 0x03) while in1 holds 0x55 valid throughout. in1_ready=0 for all three beats. 0x55 appears immediately after 0x03, with sel=1.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1. out_data, out_last and sel are frozen, and both readys=0. Raising out_ready drains and refills in the same cycle.
- Assert rst_n low mid-packet after 1 of 3 beats from in1: outputs go to 0 immediately. After release, in0 and in1 both valid gives channel 0 granted first.
- Lock with a gap: in1 packet (last=0), then in1_valid low for 2 cycles while in0 is valid. in0 is never granted until in1 delivers its last beat.

Source files
------------

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two packet sources, the arbiter, and the downstream 2:1 mux stage.
// The slave modport is the arbiter's view; master is the view of whatever drives the sources.
interface mux2_rr_arbiter_if #(
    parameter int W = 8
);
    logic         in0_valid;
    logic [W-1:0] in0_data;
    logic         in0_last;
    logic         in0_ready;

    logic         in1_valid;
    logic [W-1:0] in1_data;
    logic         in1_last;
    logic         in1_ready;

    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_ready;
    logic         sel;

    modport slave (
        input  in0_valid, in0_data, in0_last,
        output in0_ready,
        input  in1_valid, in1_data, in1_last,
        output in1_ready,
        output out_valid, out_data, out_last, sel,
        input  out_ready
    );

    modport master (
        output in0_valid, in0_data, in0_last,
        input  in0_ready,
        output in1_valid, in1_data, in1_last,
        input  in1_ready,
        input  out_valid, out_data, out_last, sel,
        output out_ready
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-channel round-robin packet arbiter with a registered output stage and registered mux select.
// A grant is held from the first beat of a packet through its last beat.
module mux2_rr_arbiter #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mux2_rr_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic           sel_q, sel_d;

    logic           load;
    logic           grant0, grant1;
    logic           acc0, acc1;

    assign load = ~out_valid_q | bus.out_ready;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in0_valid && bus.in1_valid) begin
                    grant0 = ~prio_q;
                    grant1 = prio_q;
                end else begin
                    grant0 = bus.in0_valid;
                    grant1 = bus.in1_valid;
                end
            end
            LOCK0:   grant0 = 1'b1;
            LOCK1:   grant1 = 1'b1;
            default: ;
        endcase
    end

    // rst_n gating keeps both readys low while reset is held, when load is 1.
    assign bus.in0_ready = rst_n & load & grant0;
    assign bus.in1_ready = rst_n & load & grant1;

    assign acc0 = bus.in0_valid & bus.in0_ready;
    assign acc1 = bus.in1_valid & bus.in1_ready;

    always_comb begin
        state_d     = (state_q == LOCK0 || state_q == LOCK1) ? state_q : IDLE;
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sel_d       = sel_q;

        if (acc0) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in0_data;
            out_last_d  = bus.in0_last;
            sel_d       = 1'b0;
            if (bus.in0_last) begin
                state_d = IDLE;
                prio_d  = 1'b1;
            end else begin
                state_d = LOCK0;
            end
        end else if (acc1) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in1_data;
            out_last_d  = bus.in1_last;
            sel_d       = 1'b1;
            if (bus.in1_last) begin
                state_d = IDLE;
                prio_d  = 1'b0;
            end else begin
                state_d = LOCK1;
            end
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sel_q       <= sel_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.sel       = sel_q;
endmodule
